// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants, fetch FSM state encoding and a small opcode helper for
// the instruction prefetch queue.
package fetch_prefetch_queue_pkg;

    // Low two bits of a halfword that mark a full 32-bit instruction.
    localparam logic [1:0] RVC_OPCODE_32 = 2'b11;

    // Width of one queue entry and of a compressed instruction.
    localparam int HALFWORD = 16;

    // Bytes in one fetched memory word and in one halfword.
    localparam int WORD_BYTES = 4;
    localparam int HALF_BYTES = 2;

    // Fetch FSM: idle, request in flight, request in flight whose data is discarded.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    // True when the halfword starts a 32-bit instruction.
    function automatic logic is_rvc32(input logic [HALFWORD-1:0] h);
        return h[1:0] == RVC_OPCODE_32;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_hw_fifo.sv
// Halfword FIFO: one or two entries pushed and popped per cycle, flush
// clears everything. The two oldest entries are always visible at the head.
module fetch_prefetch_queue_hw_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic                    i_push2,
    input  logic [HALFWORD-1:0]     i_din0,
    input  logic [HALFWORD-1:0]     i_din1,
    input  logic                    i_pop,
    input  logic                    i_pop2,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [HALFWORD-1:0]     o_head0,
    output logic [HALFWORD-1:0]     o_head1
);

    localparam int PW = $clog2(DEPTH);

    logic [HALFWORD-1:0] r_mem [DEPTH];
    logic [PW-1:0]       r_wr;
    logic [PW-1:0]       r_rd;
    logic [PW:0]         r_count;

    logic [PW-1:0]       w_wr1;
    logic [PW-1:0]       w_rd1;
    logic [PW:0]         w_push_n;
    logic [PW:0]         w_pop_n;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign w_wr1    = r_wr + PW'(1);
    assign w_rd1    = r_rd + PW'(1);
    assign w_push_n = i_push ? (i_push2 ? (PW+1)'(2) : (PW+1)'(1)) : '0;
    assign w_pop_n  = i_pop  ? (i_pop2  ? (PW+1)'(2) : (PW+1)'(1)) : '0;

    // Storage write; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr] <= i_din0;
            if (i_push2) begin
                r_mem[w_wr1] <= i_din1;
            end
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + w_push_n[PW-1:0];
            r_rd    <= r_rd + w_pop_n[PW-1:0];
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    assign o_count = r_count;
    assign o_head0 = r_mem[r_rd];
    assign o_head1 = r_mem[w_rd1];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: fetches aligned words over req/ack, buffers
// them as halfwords and presents 16/32-bit instructions with their PC on a
// valid/ready interface. A redirect flushes the queue and restarts fetch.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_addr_in,
    output logic              imem_req_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    input  logic              imem_ack_in,
    input  logic [31:0]       imem_rdata_in,
    output logic              inst_valid_out,
    input  logic              inst_ready_in,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc_out,
    output logic              inst_step_out
);

    localparam int                CW       = $clog2(QDEPTH) + 1;
    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] HW_MASK  = ~ADDR_W'(HALF_BYTES - 1);
    localparam logic [ADDR_W-1:0] WD_MASK  = ~ADDR_W'(WORD_BYTES - 1);
    // A new request is only issued when two free slots remain, so a full
    // word always fits when its ack arrives.
    localparam logic [CW:0]       ROOM_MAX = (CW+1)'(QDEPTH - 2);

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                r_skip;
    logic                w_skip_nxt;
    logic [ADDR_W-1:0]   r_drop_addr;
    logic [ADDR_W-1:0]   w_drop_addr_nxt;
    logic [ADDR_W-1:0]   r_pc;

    logic                w_push;
    logic                w_push2;
    logic [HALFWORD-1:0] w_din0;
    logic [HALFWORD-1:0] w_din1;
    logic [CW-1:0]       w_count;
    logic [HALFWORD-1:0] w_head0;
    logic [HALFWORD-1:0] w_head1;

    logic                w_have1;
    logic                w_have2;
    logic                w_is32;
    logic [HALFWORD-1:0] w_h0;
    logic [HALFWORD-1:0] w_h1;
    logic                w_xfer;
    logic [CW:0]         w_pop_n;
    logic [CW:0]         w_cnt_after;

    fetch_prefetch_queue_hw_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_in),
        .i_push  (w_push),
        .i_push2 (w_push2),
        .i_din0  (w_din0),
        .i_din1  (w_din1),
        .i_pop   (w_xfer),
        .i_pop2  (w_is32),
        .o_count (w_count),
        .o_head0 (w_head0),
        .o_head1 (w_head1)
    );

    // A misaligned start keeps only the upper halfword of the first word.
    assign w_push2 = !r_skip;
    assign w_din0  = r_skip ? imem_rdata_in[2*HALFWORD-1:HALFWORD]
                            : imem_rdata_in[HALFWORD-1:0];
    assign w_din1  = imem_rdata_in[2*HALFWORD-1:HALFWORD];

    // Instruction assembly at the queue head; masked so an empty queue reads as zero.
    assign w_have1        = (w_count != '0);
    assign w_have2        = (w_count >= CW'(2));
    assign w_is32         = w_have1 && is_rvc32(w_head0);
    assign w_h0           = w_have1 ? w_head0 : '0;
    assign w_h1           = w_have2 ? w_head1 : '0;
    assign inst_valid_out = !redirect_in && (w_is32 ? w_have2 : w_have1);
    assign inst_out       = w_is32 ? {w_h1, w_h0} : {{HALFWORD{1'b0}}, w_h0};
    assign inst_step_out  = w_have1 && !w_is32;
    assign inst_pc_out    = r_pc;
    assign w_xfer         = inst_valid_out && inst_ready_in;

    // Occupancy after this cycle's ack push and consumer pop, for the re-request decision.
    assign w_pop_n     = w_xfer ? (w_is32 ? (CW+1)'(2) : (CW+1)'(1)) : '0;
    assign w_cnt_after = {1'b0, w_count} + (r_skip ? (CW+1)'(1) : (CW+1)'(2)) - w_pop_n;

    assign imem_req_out  = r_req;
    assign imem_addr_out = r_addr;

    // Fetch FSM next state: redirect first, then normal request sequencing.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_skip_nxt      = r_skip;
        w_drop_addr_nxt = r_drop_addr;
        w_push          = 1'b0;
        if (redirect_in) begin
            if (r_state != FS_IDLE && !imem_ack_in) begin
                // The in-flight response must still be absorbed before restarting.
                w_state_nxt     = FS_DROP;
                w_drop_addr_nxt = redirect_addr_in & HW_MASK;
            end else begin
                w_state_nxt = FS_IDLE;
                w_addr_nxt  = redirect_addr_in & WD_MASK;
                w_skip_nxt  = redirect_addr_in[1];
            end
        end else begin
            unique case (r_state)
                FS_IDLE: begin
                    if ({1'b0, w_count} <= ROOM_MAX) begin
                        w_state_nxt = FS_REQ;
                    end
                end
                FS_REQ: begin
                    if (imem_ack_in) begin
                        w_push      = 1'b1;
                        w_skip_nxt  = 1'b0;
                        w_addr_nxt  = r_addr + ADDR_W'(WORD_BYTES);
                        w_state_nxt = (w_cnt_after <= ROOM_MAX) ? FS_REQ : FS_IDLE;
                    end
                end
                FS_DROP: begin
                    if (imem_ack_in) begin
                        w_state_nxt = FS_REQ;
                        w_addr_nxt  = r_drop_addr & WD_MASK;
                        w_skip_nxt  = r_drop_addr[1];
                    end
                end
                default: w_state_nxt = FS_IDLE;
            endcase
        end
    end

    // Fetch FSM state, registered request and fetch address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FS_IDLE;
            r_req       <= 1'b0;
            r_addr      <= RST_PC & WD_MASK;
            r_skip      <= RST_PC[1];
            r_drop_addr <= RST_PC & HW_MASK;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= (w_state_nxt != FS_IDLE);
            r_addr      <= w_addr_nxt;
            r_skip      <= w_skip_nxt;
            r_drop_addr <= w_drop_addr_nxt;
        end
    end

    // Head PC: jumps on redirect, otherwise steps by the consumed instruction size.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RST_PC;
        end else if (redirect_in) begin
            r_pc <= redirect_addr_in & HW_MASK;
        end else if (w_xfer) begin
            r_pc <= r_pc + (w_is32 ? ADDR_W'(WORD_BYTES) : ADDR_W'(HALF_BYTES));
        end
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Front-end prefetch unit that sits directly upstream of the IF_ID pipeline register. It fetches aligned 32-bit words from instruction memory over a req/ack handshake and buffers them as halfwords. From the buffer it assembles 16-bit (compressed) and 32-bit instructions, including 32-bit instructions that straddle a word boundary. Each instruction is presented with its PC and a step flag on a valid/ready interface; a redirect from the branch unit (pcSrc) flushes the queue and restarts fetch.

Parameters:
ADDR_W, 8, PC / instruction-memory byte-address width; all address arithmetic is modulo 2^ADDR_W
QDEPTH, 4, halfword queue depth; power of two, minimum 4
RESET_PC, 0, fetch start address after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
redirect_in  input  1  flush the queue and restart fetch at redirect_addr_in
redirect_addr_in  input  ADDR_W  new PC; bit 0 ignored
imem_req_out  output  1  fetch request; held high until ack
imem_addr_out  output  ADDR_W  word-aligned fetch address; bits [1:0] = 0
imem_ack_in  input  1  fetch data valid this cycle; may arrive in the same cycle as req or later
imem_rdata_in  input  32  fetched word, little-endian halfwords
inst_valid_out  output  1  instruction available
inst_ready_in  input  1  consumer accepts the instruction (~stall)
inst_out  output  32  raw instruction; upper 16 bits zero when compressed
inst_pc_out  output  ADDR_W  byte address of inst_out
inst_step_out  output  1  1 = 16-bit instruction, 0 = 32-bit

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: imem_req_out=0, imem_addr_out=RESET_PC & ~3, inst_valid_out=0, inst_out=0, inst_pc_out=RESET_PC, inst_step_out=0. The queue is empty, no request is outstanding, and the discard flag is clear.
- Fetch FSM: IDLE, REQ, DROP.
  - IDLE -> REQ when free slots >= 2 and no redirect. imem_req_out is registered, so the first request after reset appears in the first cycle after rst deasserts.
  - REQ: hold address and req until imem_ack_in.
    - On ack with no redirect: push the word and advance the fetch address by 4. Go back to REQ if free slots after the push and any same-cycle pop are >= 2; otherwise go to IDLE.
  - Redirect while in REQ without a same-cycle ack: go to DROP. The request stays asserted until ack, and that response is discarded.
  - DROP -> REQ at the redirect address in the cycle after ack.
- Only one request is outstanding at a time.
- Misaligned start: if the fetch start address has bit 1 = 1, only the upper halfword of the first word is pushed.
- Assembly at the queue head, on halfword h0:
  - h0[1:0] != 2'b11: compressed. Valid when count >= 1. inst_out = {16'h0, h0}, step = 1, pop 1.
  - Otherwise 32-bit. Valid when count >= 2. inst_out = {h1, h0}, step = 0, pop 2.
- Output timing: inst_* outputs are combinational from the queue head. Head PC is a register that advances by 2 or 4 on each accepted transfer.
- Transfer: a transfer happens when valid && ready. If valid && !ready, all inst_* outputs hold stable.
- Same-cycle events:
  - Push and pop in the same cycle are allowed; the count is updated by the net change.
  - Pushing into a full queue is impossible by construction; the free-slot check includes the outstanding request.
- Redirect priority: redirect beats push, pop, and ack.
  - In the redirect cycle inst_valid_out is forced to 0 and any ready is ignored.
  - Next cycle: queue empty, head PC = redirect_addr_in & ~1, fetch address = redirect_addr_in & ~3.
- Wrap-around: fetch address and PC wrap at 2^ADDR_W. Queue pointers wrap at QDEPTH.
- Reset mid-operation: all state is cleared immediately. Any ack arriving during or after reset that belongs to a pre-reset request is ignored.

Decomposition:
- Shared package:
  - RVC_OPCODE_32 = 2'b11
  - HALFWORD = 16
  - WORD_BYTES = 4
  - fetch FSM state encoding
- Sub-module: hw_fifo, a parameterised halfword FIFO.
  - Push 1 or 2 halfwords, pop 1 or 2 halfwords, flush.
  - Exposes count, head0 and head1.
- Top-level logic: FSM, PC tracking, and assembly.

Test Plan:
1. Reset, memory words at 0/4/8 = 32'h00A00513, 32'h00B00593, 32'h00C00613; ack in the same cycle; ready=1 -> three instructions at pc 0, 4, 8, step=0, data as stored; first req one cycle after rst drops.
2. Word at 0 = 32'h05054501 -> pc0 inst 32'h00004501 step1, then pc2 inst 32'h00000505 step1.
3. Straddle: word0 = 32'h05134501, word4 = 32'h000000A0 -> pc0 32'h00004501 step1, then pc2 32'h00A00513 step0, valid only after the second fetch.
4. ready=0 for 10 cycles with 3-cycle ack latency -> req stops once the queue is full; when ready rises, all instructions come out in order with no loss or duplication.
5. Redirect to 8'h12 while a request for 8'h08 is pending (ack 2 cycles later) -> the 8'h08 data is dropped, the next fetch is at 8'h10, and the first output is pc 8'h12 with the upper halfword of word 8'h10.
6. Assert rst mid-REQ with the queue half full -> outputs are at reset values immediately (asynchronously); fetch restarts at RESET_PC after release.
